dac_spi_writer: RTL

DAC_SPI_WRITER -- requirements
Module: dac_spi_writer

---
 rtl/dac_spi_writer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dac_spi_writer.sv
// SPI writer for a 12-bit dual DAC: accepts one sample per handshake, shifts a
// 16-bit command frame out in mode 0, then strobes LDAC to update the output.
module dac_spi_writer #(
  parameter int CLK_DIV = 4,
  parameter bit BUF_EN  = 1'b0,
  parameter bit GAIN_1X = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        ldac_n,
  output logic        busy
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("dac_spi_writer: CLK_DIV must be in 1..255");
  end

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LATCH
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  div, div_nx;
  logic [4:0]  bit_cnt, bit_nx;
  logic        phase, phase_nx;
  logic [15:0] shreg, shreg_nx;
  logic        armed;
  logic        handshake;
  logic        div_done;
  logic        frame_nx;

  assign sample_ready = armed && (state == IDLE);
  assign busy         = (state != IDLE);
  assign handshake    = sample_valid && sample_ready;
  assign div_done     = (div == 8'd0);
  assign frame_nx     = (state_nx == SETUP) || (state_nx == SHIFT) || (state_nx == HOLD);

  always_comb begin
    state_nx = state;
    div_nx   = div;
    bit_nx   = bit_cnt;
    phase_nx = phase;
    shreg_nx = shreg;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_nx = SETUP;
          div_nx   = DIV_LOAD;
          bit_nx   = 5'd0;
          phase_nx = 1'b0;
          shreg_nx = {1'b0, BUF_EN, GAIN_1X, 1'b1, sample};
        end
      end
      SETUP: begin
        if (div_done) begin
          state_nx = SHIFT;
          div_nx   = DIV_LOAD;
          bit_nx   = 5'd0;
          phase_nx = 1'b0;
        end else begin
          div_nx = div - 8'd1;
        end
      end
      SHIFT: begin
        if (!div_done) begin
          div_nx = div - 8'd1;
        end else begin
          div_nx = DIV_LOAD;
          if (!phase) begin
            phase_nx = 1'b1;
          end else if (bit_cnt == 5'd15) begin
            state_nx = HOLD;
            phase_nx = 1'b0;
          end else begin
            // next bit's low phase begins: present the next data bit on mosi
            bit_nx   = bit_cnt + 5'd1;
            phase_nx = 1'b0;
            shreg_nx = {shreg[14:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (div_done) begin
          state_nx = LATCH;
          div_nx   = DIV_LOAD;
        end else begin
          div_nx = div - 8'd1;
        end
      end
      LATCH: begin
        if (div_done) begin
          state_nx = IDLE;
          div_nx   = 8'd0;
          bit_nx   = 5'd0;
        end else begin
          div_nx = div - 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div     <= 8'd0;
      bit_cnt <= 5'd0;
      phase   <= 1'b0;
      shreg   <= 16'd0;
      armed   <= 1'b0;
    end else begin
      state   <= state_nx;
      div     <= div_nx;
      bit_cnt <= bit_nx;
      phase   <= phase_nx;
      shreg   <= shreg_nx;
      armed   <= 1'b1;
    end
  end

  // Pin outputs decoded from next-state values so every pin is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      cs_n   <= 1'b1;
      ldac_n <= 1'b1;
    end else begin
      sclk   <= (state_nx == SHIFT) && phase_nx;
      mosi   <= frame_nx ? shreg_nx[15] : 1'b0;
      cs_n   <= !frame_nx;
      ldac_n <= (state_nx != LATCH);
    end
  end

endmodule
